// File: rtl/mult_pkg.sv
// Shared widths and vector types for the multiplier final-adder stage.
package mult_pkg;

    localparam int MULT_W  = 32;
    localparam int MULT_HW = MULT_W / 2;

    typedef logic [MULT_W-1:0]  mult_vec_t;
    typedef logic [MULT_HW-1:0] half_vec_t;

endpackage

// File: rtl/pipe_stage_ctrl.sv
// Valid/ready control for one single-entry pipeline stage.
// The stage accepts a new entry when it is empty or when its current entry
// is taken downstream in the same cycle, so a full pipeline streams with no
// bubbles. up_ready depends only on the stage state and dn_ready, never on
// up_valid.
module pipe_stage_ctrl
    import mult_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic up_valid,
    input  logic dn_ready,
    output logic up_ready,
    output logic load,
    output logic valid
);

    logic valid_reg;

    assign up_ready = !valid_reg || dn_ready;
    assign load     = up_valid && up_ready;
    assign valid    = valid_reg;

    // Occupancy: refill from upstream whenever the slot is free or draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
        end else if (up_ready) begin
            valid_reg <= up_valid;
        end
    end

endmodule

// File: rtl/mult_final_adder.sv
// Final carry-propagate adder for a Wallace-tree multiplier:
// product = (sum_vec + carry_vec) mod 2^W, with valid/ready on both sides
// and a 16-bit count of delivered products.
// Build option MULT_SPLIT_ADD_EN: split the add into a low-half stage and a
// high-half stage (2-cycle latency, 2 entries). Without it a single stage
// does the whole add (1-cycle latency, 1 entry).
module mult_final_adder
    import mult_pkg::*;
#(
    parameter int W = MULT_W
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] sum_vec,
    input  logic [W-1:0] carry_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] product,
    output logic [15:0]  prod_cnt
);

    localparam int HW = W / 2;

    logic [W-1:0] product_reg;
    logic [15:0]  cnt_reg;

`ifdef MULT_SPLIT_ADD_EN

    logic          s1_valid;
    logic          s1_load;
    logic          s2_up_ready;
    logic          s2_load;
    logic [HW-1:0] lo_sum_reg;
    logic          lo_carry_reg;
    logic [HW-1:0] sum_hi_reg;
    logic [HW-1:0] carry_hi_reg;
    logic [HW:0]   lo_add;
    logic [HW-1:0] hi_add;

    // Stage 1: low-half add; in_ready comes straight from its control.
    pipe_stage_ctrl u_stage1_ctrl (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .up_valid (in_valid),
        .dn_ready (s2_up_ready),
        .up_ready (in_ready),
        .load     (s1_load),
        .valid    (s1_valid)
    );

    // Stage 2: high-half add; its valid bit is the output valid.
    pipe_stage_ctrl u_stage2_ctrl (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .up_valid (s1_valid),
        .dn_ready (out_ready),
        .up_ready (s2_up_ready),
        .load     (s2_load),
        .valid    (out_valid)
    );

    // One extra bit on the low add captures the carry into the high half.
    assign lo_add = {1'b0, sum_vec[HW-1:0]} + {1'b0, carry_vec[HW-1:0]};
    // High add drops its own carry-out: the result is modulo 2^W.
    assign hi_add = sum_hi_reg + carry_hi_reg + {{(HW-1){1'b0}}, lo_carry_reg};

    // Stage 1 data: partial low sum, its carry, and the untouched high halves.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lo_sum_reg   <= '0;
            lo_carry_reg <= 1'b0;
            sum_hi_reg   <= '0;
            carry_hi_reg <= '0;
        end else if (s1_load) begin
            lo_sum_reg   <= lo_add[HW-1:0];
            lo_carry_reg <= lo_add[HW];
            sum_hi_reg   <= sum_vec[W-1:HW];
            carry_hi_reg <= carry_vec[W-1:HW];
        end
    end

    // Stage 2 data: assemble the full product from both halves.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            product_reg <= '0;
        end else if (s2_load) begin
            product_reg <= {hi_add, lo_sum_reg};
        end
    end

`else

    logic s1_load;

    // Single stage: its valid bit is the output valid.
    pipe_stage_ctrl u_stage1_ctrl (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .up_valid (in_valid),
        .dn_ready (out_ready),
        .up_ready (in_ready),
        .load     (s1_load),
        .valid    (out_valid)
    );

    // Full-width add; the carry-out falls off the top.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            product_reg <= '0;
        end else if (s1_load) begin
            product_reg <= sum_vec + carry_vec;
        end
    end

`endif

    // Delivered-product counter, wraps naturally at 16 bits.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_reg <= 16'h0000;
        end else if (out_valid && out_ready) begin
            cnt_reg <= cnt_reg + 16'h0001;
        end
    end

    assign product  = product_reg;
    assign prod_cnt = cnt_reg;

endmodule

// File: tb/tb_mult_final_adder.sv
// Self-checking bench for mult_final_adder. A queue of accepted sums (with
// acceptance cycle) predicts in_ready, out_valid, product and prod_cnt every
// cycle; directed cases pin literal results. Honors MULT_SPLIT_ADD_EN.
module tb_mult_final_adder;
    import mult_pkg::*;

    localparam int W = 32;
`ifdef MULT_SPLIT_ADD_EN
    localparam int LAT = 2;
    localparam int CAP = 2;
`else
    localparam int LAT = 1;
    localparam int CAP = 1;
`endif

    logic         sys_clk;
    logic         sys_rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] sum_vec;
    logic [W-1:0] carry_vec;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] product;
    logic [15:0]  prod_cnt;

    mult_final_adder #(.W(W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_vec   (sum_vec),
        .carry_vec (carry_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .prod_cnt  (prod_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%h exp=0x%h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] v;
        int          t;
    } ent_t;

    ent_t        q[$];
    logic [15:0] model_cnt = 16'h0000;
    int          cyc = 0;
    int          occ;
    logic        exp_ov;
    logic        hold_prev = 1'b0;
    logic [31:0] prod_prev;
    logic [31:0] sum_tmp;
    ent_t        ent;

    always @(posedge sys_clk) cyc++;

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_product", product, 32'd0);
            chk("rst_prod_cnt", {16'd0, prod_cnt}, 32'd0);
            q.delete();
            model_cnt = 16'h0000;
            hold_prev = 1'b0;
        end else begin
            occ = q.size();
            chk("in_ready", {31'd0, in_ready}, {31'd0, (occ < CAP) || out_ready});
            if (occ > 0) exp_ov = ((cyc - q[0].t) >= LAT);
            else         exp_ov = 1'b0;
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
            if (out_valid && occ > 0) chk("product", product, q[0].v);
            chk("prod_cnt", {16'd0, prod_cnt}, {16'd0, model_cnt});
            if (hold_prev) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_product", product, prod_prev);
            end
            hold_prev = out_valid && !out_ready;
            prod_prev = product;
            if (out_valid && out_ready && occ > 0) begin
                void'(q.pop_front());
                model_cnt = model_cnt + 16'h0001;
            end
            if (in_valid && in_ready) begin
                sum_tmp = sum_vec + carry_vec;
                ent.v = sum_tmp;
                ent.t = cyc;
                q.push_back(ent);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic align();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push(input logic [31:0] s, input logic [31:0] c);
        int n;
        sum_vec   = s;
        carry_vec = c;
        in_valid  = 1'b1;
        n = 0;
        @(negedge sys_clk);
        while (!in_ready && n < 50) begin
            @(negedge sys_clk);
            n++;
        end
        if (!in_ready) chk("push_timeout", {31'd0, in_ready}, 32'd1);
        align();
        in_valid = 1'b0;
    endtask

    task automatic directed(input logic [31:0] s, input logic [31:0] c,
                            input logic [31:0] exp, input string name);
        int lat;
        push(s, c);
        lat = 0;
        do begin
            @(negedge sys_clk);
            lat++;
        end while (!out_valid && lat < 10);
        chk({name, "_latency"}, lat, LAT);
        chk({name, "_product"}, product, exp);
        align();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge sys_clk);
            n++;
        end
        chk("drain_empty", q.size(), 32'd0);
        align();
    endtask

    // ---------------- test sequence ----------------
    int t0;
    int acc;

    initial begin
        sys_rst_n = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sum_vec   = '0;
        carry_vec = '0;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
        align();

        // Literal cases: carry across bit 15, carry-out discard, plain add
        directed(32'h0000FFFF, 32'h00000001, 32'h00010000, "lo_carry");
        @(negedge sys_clk);
        chk("cnt_after_first", {16'd0, prod_cnt}, 32'd1);
        align();
        directed(32'hFFFFFFFF, 32'h00000001, 32'h00000000, "carry_out_drop");
        directed(32'h00008000, 32'h00008000, 32'h00010000, "bit15_pair");
        directed(32'h12345678, 32'h11111111, 32'h23456789, "plain_add");
        directed(32'h0000FFFF, 32'hFFFF0001, 32'h00000000, "carry_ripple_wrap");
        @(negedge sys_clk);
        chk("cnt_after_directed", {16'd0, prod_cnt}, 32'd5);
        align();

        // Back-to-back stream: one accept per cycle
        t0 = cyc;
        for (int i = 0; i < 100; i++) push($urandom, $urandom);
        chk("stream_cycles", cyc - t0, 32'd100);
        drain();
        @(negedge sys_clk);
        chk("cnt_after_stream", {16'd0, prod_cnt}, 32'd105);
        align();

        // Backpressure: input stalls once every stage is full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sum_vec   = $urandom;
        carry_vec = $urandom;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            if (in_ready) acc++;
            align();
            sum_vec   = $urandom;
            carry_vec = $urandom;
        end
        chk("bp_accepts", acc, CAP);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Random valid/ready mix
        for (int i = 0; i < 300; i++) begin
            in_valid  = $urandom_range(0, 1) == 1;
            sum_vec   = $urandom;
            carry_vec = $urandom;
            out_ready = $urandom_range(0, 3) != 0;
            align();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with entries in flight
        out_ready = 1'b0;
        for (int i = 0; i < CAP; i++) push($urandom, $urandom);
        chk("inflight_count", q.size(), CAP);
        sys_rst_n = 1'b0;
        repeat (2) align();
        sys_rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge sys_clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_prod_cnt", {16'd0, prod_cnt}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            chk("no_stale_output", {31'd0, out_valid}, 32'd0);
        end
        align();

        // Counter wrap: 65537 deliveries from zero
        for (int i = 0; i < 65537; i++) push($urandom, $urandom);
        drain();
        @(negedge sys_clk);
        chk("cnt_wrap", {16'd0, prod_cnt}, 32'h00000001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_final_adder.md
MULT_FINAL_ADDER -- requirements
Module: mult_final_adder

Interface
REQ-001 SHALL have parameter W, default 32, giving the width of the sum/carry vectors and the product (even, >=8).
REQ-002 SHALL have port sys_clk  input  1  single clock; all state is updated on the rising edge.
REQ-003 SHALL have port sys_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  sum/carry pair from the Wallace-tree compressor array is valid.
REQ-005 SHALL have port in_ready  output  1  block accepts the pair this cycle.
REQ-006 SHALL have port sum_vec  input  W  tree sum row.
REQ-007 SHALL have port carry_vec  input  W  tree carry row, already left-aligned by the tree.
REQ-008 SHALL have port out_valid  output  1  product is valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the product.
REQ-010 SHALL have port product  output  W  (sum_vec + carry_vec) mod 2^W.
REQ-011 SHALL have port prod_cnt  output  16  count of products delivered (out_valid && out_ready); wraps 0xFFFF->0x0000.

Function
REQ-012 A transfer SHALL occur on an input or output port only in a cycle where valid && ready.
REQ-013 product SHALL equal the W-bit modular sum of the accepted sum_vec and carry_vec; bit W carry-out is discarded.
REQ-014 Products SHALL leave in acceptance order, with no loss or duplication.
REQ-015 Each pipeline stage SHALL hold one entry: valid bit plus data.
REQ-016 A stage SHALL load when it is empty or its entry moves on in the same cycle.
REQ-017 in_ready SHALL be !s1_valid || s1_advance, combinational from out_ready; no combinational path from in_valid to in_ready.
REQ-018 With out_ready held high, throughput SHALL be one product per cycle.
REQ-019 With out_ready low, the block SHALL hold product and out_valid stable until accepted, and SHALL stall upstream once all stages are full.
REQ-020 A simultaneous accept at input and delivery at output SHALL keep occupancy unchanged with no bubble.
REQ-021 prod_cnt SHALL increment by exactly 1 per delivered product, including when a delivery and an accept happen in the same cycle.

Reset
REQ-022 While sys_rst_n is low, all stage valid bits, out_valid, product and prod_cnt SHALL be 0.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight entries immediately, with no output transfer afterwards.
REQ-024 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-025 The macro MULT_SPLIT_ADD_EN SHALL select the adder structure.
REQ-026 With MULT_SPLIT_ADD_EN defined, the add SHALL be split into two stages:
- stage 1 adds the low W/2 bits and registers the partial sum, the carry, and the high operand halves;
- stage 2 adds the high halves plus the registered carry;
- latency from input accept to out_valid SHALL be 2 cycles.
REQ-027 Without MULT_SPLIT_ADD_EN, a single stage SHALL perform the full W-bit add, with latency 1 cycle and in_ready = !out_valid || out_ready.
REQ-028 Function, ordering, prod_cnt and reset behaviour SHALL be identical in both builds; only latency and capacity (2 vs 1 entries) differ.

Structure
REQ-029 A shared package mult_pkg SHALL hold:
- the W default (MULT_W = 32);
- the half width MULT_HW = MULT_W/2;
- the typedefs mult_vec_t [MULT_W-1:0] and half_vec_t [MULT_HW-1:0].
REQ-030 Each stage's valid/ready register control SHALL be one sub-module, pipe_stage_ctrl (inputs up_valid and dn_ready; outputs up_ready, load, valid). It SHALL be instantiated twice with the macro and once without.

Verification
REQ-031 After reset with out_ready=1, sum_vec=0x0000FFFF and carry_vec=0x00000001 accepted -> product=0x00010000 with out_valid after 2 cycles (1 without the macro), and prod_cnt=1.
REQ-032 sum_vec=0xFFFFFFFF, carry_vec=0x00000001 -> product=0x00000000 (carry-out discarded); the low-to-high carry across bit 15 is verified.
REQ-033 Back-to-back stream of 100 random pairs with out_ready=1 -> 100 correct products, one per cycle, in order; prod_cnt=100.
REQ-034 out_ready=0 for 10 cycles while in_valid=1 -> in_ready falls after 2 accepts (1 without the macro); product stays stable; no loss when out_ready returns to 1.
REQ-035 sys_rst_n pulsed low while 2 entries are in flight -> out_valid=0, prod_cnt=0 and in_ready=1 after release; no stale product is delivered.
REQ-036 prod_cnt preloaded near wrap by delivering 65537 products -> prod_cnt=0x0001.
